// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one word read in flight,
// and buffers PC-tagged words in a small FIFO that feeds decode.
module if_fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 16,
  parameter int                 DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  pending_pc;

  logic [DATA_W-1:0]  fifo_data [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  hold_data;
  logic [ADDR_W-1:0]  hold_pc;

  logic full;
  logic empty;
  logic grant;
  logic push;
  logic pop;

  // Handshakes: a memory read is accepted on a cycle with mem_req & mem_gnt, and its
  // data returns on a later mem_rvalid; a decode transfer happens on inst_valid & inst_ready.
  // A branch kills both sides that cycle: no request, no decode transfer, no FIFO push.
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign mem_req    = (state == ST_IDLE) && !full && !branch_taken;
  assign mem_addr   = fetch_pc;
  assign pc_out     = fetch_pc;
  assign grant      = mem_req && mem_gnt;
  assign push       = (state == ST_WAIT) && mem_rvalid && !branch_taken;
  assign inst_valid = !empty && !branch_taken;
  assign pop        = inst_valid && inst_ready;

  // An empty FIFO keeps showing the last head so decode never sees stale slot contents.
  assign inst_data  = empty ? hold_data : fifo_data[rd_ptr];
  assign inst_pc    = empty ? hold_pc   : fifo_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
    end else if (branch_taken) begin
      fetch_pc <= branch_target;
      case (state)
        // The in-flight read still has to come back; remember to throw it away.
        ST_WAIT: state <= mem_rvalid ? ST_IDLE : ST_DROP;
        ST_DROP: state <= mem_rvalid ? ST_IDLE : ST_DROP;
        default: state <= ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_BOOT: state <= ST_IDLE;
        ST_IDLE: begin
          if (grant) begin
            pending_pc <= fetch_pc;
            fetch_pc   <= fetch_pc + ADDR_W'(1);
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) state <= ST_IDLE;
        end
        ST_DROP: begin
          if (mem_rvalid) state <= ST_IDLE;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (branch_taken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_pc[wr_ptr]   <= pending_pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_pc   <= '0;
    end else if (!empty) begin
      hold_data <= fifo_data[rd_ptr];
      hold_pc   <= fifo_pc[rd_ptr];
    end
  end

  // Structural invariants of the one-outstanding-read scheme.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full));
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req && !mem_gnt && !branch_taken) |=> (mem_addr == $past(mem_addr)));

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly downstream of the PC block. It owns the fetch PC and issues word reads to instruction memory over a req/gnt/rvalid interface, with at most one read outstanding. Returned words, each tagged with its PC, go into a small FIFO. The FIFO presents them to decode with a valid/ready handshake. A taken branch redirects the fetch PC, flushes the FIFO and discards any in-flight response.

Parameters:
ADDR_W, 16, width of instruction address (word addressed)
DATA_W, 16, width of instruction word
DEPTH, 2, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, fetch PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
branch_taken  in  1  single-cycle redirect strobe
branch_target  in  ADDR_W  redirect address, sampled when branch_taken=1
mem_req  out  1  read request
mem_addr  out  ADDR_W  read address, equals fetch PC
mem_gnt  in  1  request accepted this cycle (mem_req & mem_gnt)
mem_rvalid  in  1  read data valid; in-order, >=1 cycle after grant
mem_rdata  in  DATA_W  read data
inst_valid  out  1  FIFO head valid to decode
inst_data  out  DATA_W  instruction word at FIFO head
inst_pc  out  ADDR_W  address of inst_data
inst_ready  in  1  decode accepts head when inst_valid=1
pc_out  out  ADDR_W  current fetch PC (next address to request)

Behaviour:
- Reset (async assert, sync release):
  - state=BOOT, fetch_pc=RESET_PC, FIFO emptied, pending_pc=0.
  - Outputs during reset: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, pc_out=RESET_PC.
- States:
  - BOOT: one cycle after reset release, no request; then IDLE.
  - IDLE: no read outstanding.
  - WAIT: read outstanding, response wanted.
  - DROP: read outstanding, response to be discarded.
- Request generation:
  - mem_req = (state==IDLE) & (count<DEPTH) & !branch_taken. Combinational, so mem_req is 0 in BOOT, WAIT and DROP.
  - mem_addr=fetch_pc.
  - The address holds stable while mem_req=1 and no grant, unless a branch redirects.
- Grant (mem_req & mem_gnt): pending_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (wraps modulo 2^ADDR_W), IDLE->WAIT.
- Response in WAIT with mem_rvalid=1 and no branch:
  - Push {mem_rdata, pending_pc} into FIFO; ->IDLE.
  - Space is guaranteed: a request is only issued when count<DEPTH.
- Response in DROP with mem_rvalid=1: data discarded; ->IDLE.
- mem_rvalid in IDLE or BOOT: ignored (protocol error, no state change).
- Branch (branch_taken=1), same cycle, highest priority:
  - fetch_pc<=branch_target; FIFO count<=0.
  - inst_valid forced 0 that cycle, so no decode transfer occurs.
  - No grant can occur that cycle, because mem_req=0.
  - If WAIT without rvalid: ->DROP. If WAIT with rvalid: data discarded, ->IDLE.
  - If DROP: stays DROP until rvalid (->IDLE). If IDLE or BOOT: ->IDLE.
  - First request to branch_target is asserted the cycle after the branch if state is IDLE.
- FIFO:
  - inst_valid=(count!=0)&!branch_taken; inst_data/inst_pc show the head entry.
  - Pop on inst_valid&inst_ready.
  - Push and pop in the same cycle are allowed; count unchanged.
  - Pop when full frees a slot; the request may issue the next cycle.
  - When empty, inst_data/inst_pc hold their last values (0 after reset).
- Throughput: with 1-cycle memory latency and inst_ready=1, one instruction every 2 cycles (one outstanding read).
- Latency:
  - First request: cycle 2 after reset release.
  - Instruction becomes visible on inst_valid the cycle after its mem_rvalid.
- Reset mid-operation: all state cleared immediately. The memory side must abandon any outstanding read; a late rvalid after reset is ignored because the block is in BOOT/IDLE.

Test Plan:
- Release reset, RESET_PC=0x0010, mem_gnt=1, rvalid 1 cycle after grant, inst_ready=1 -> mem_req first high cycle 2; decode receives (0x0010,d0), (0x0011,d1), (0x0012,d2) in order, one per 2 cycles.
- inst_ready=0 for 10 cycles -> exactly 2 words buffered, mem_req stays 0 while full. Raise inst_ready -> 2 pops back-to-back, then fetch resumes at next sequential PC.
- Grant at 0x0020, branch_taken to 0x0100 before rvalid -> state DROP, returned word not delivered. Next request addr=0x0100 after rvalid; inst_pc of next delivered entry=0x0100.
- branch_taken in the same cycle as mem_rvalid for 0x0030, FIFO holding 1 entry -> no entries delivered, inst_valid=0 that cycle. mem_req for target asserted next cycle.
- mem_gnt held 0 for 5 cycles at addr 0x0040 -> mem_req=1 and mem_addr=0x0040 stable throughout; pc_out=0x0040.
- fetch_pc=0xFFFF granted -> next mem_addr=0x0000 (wrap); assert rst_n=0 while in WAIT -> outputs return to reset values immediately; late rvalid ignored; fetch restarts at RESET_PC.
